ifu_fetch_ctrl: RTL
===================

// Module: ifu_fetch_ctrl
// PURPOSE
//  Fetch sequencer in front of the core's PC logic. Owns the PC, issues one instruction-bus read at a time,
//  buffers the returned word and hands it to decode over valid/ready. Applies branch/trap redirects at any point,
//  discarding stale in-flight responses. Single outstanding request; no prediction.
// PARAMETERS
//  XLEN        32            data/address width
//  PC_RST_VEC  32'h00000000  PC after reset
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous reset, active-high
//  pc_branch      in   1     branch/jump redirect request
//  target_pc      in   XLEN  branch target
//  trap           in   1     trap redirect request; priority over pc_branch
//  trap_pc        in   XLEN  trap vector
//  ibus_req_valid out  1     read request valid
//  ibus_req_ready in   1     bus accepts request
//  ibus_req_addr  out  XLEN  read address, word aligned
//  ibus_rsp_valid in   1     read data returned (always accepted)
//  ibus_rsp_data  in   32    instruction word
//  ibus_rsp_err   in   1     bus error on this response
//  inst_valid     out  1     instruction available to decode
//  inst_ready     in   1     decode consumes instruction
//  inst           out  32    instruction word (0 on fault)
//  inst_pc        out  XLEN  PC of inst
//  inst_fault     out  2     0 none, 1 bus error, 2 misaligned PC
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high on rst.
//  - Reset: pc=PC_RST_VEC, state=REQ, drop=0, inst_valid=0, inst=0, inst_pc=0, inst_fault=0.
//    The first cycle after rst deasserts drives ibus_req_valid=1, addr=PC_RST_VEC.
//  - Redirect = trap | pc_branch. Next PC = trap ? trap_pc : target_pc.
//  - States:
//    REQ : req_valid=1, addr=req_addr (latched on REQ entry); req_valid/addr hold stable until ready.
//          ready -> WAIT.
//    WAIT: rsp_valid -> capture data/err/pc into the buffer -> HOLD; if drop=1, discard, clear drop -> REQ.
//    HOLD: inst_valid=1; inst_valid & inst_ready -> pc+=4 -> REQ.
//    FLT : misaligned PC (pc[1:0]!=0) entering REQ. No bus request; buffer fault=2, inst=0 -> HOLD.
//  - Latency: req_accept -> rsp -> inst_valid on the cycle after rsp_valid.
//    Minimum 3 cycles/instruction with zero-wait bus.
//  - Redirect handling, all states: pc <= redirect target; redirects in the same cycle collapse to trap_pc.
//    REQ not accepted : request stays pending with the old address (no withdraw); drop<=1.
//    REQ accepted same cycle: -> WAIT, drop<=1.
//    WAIT             : drop<=1. If rsp_valid in the same cycle, discard it -> REQ directly.
//    HOLD             : buffer invalidated; inst_valid=0 next cycle; -> REQ at the target.
//                       With inst_ready in the same cycle, the handshake completes but pc=target, not pc+4.
//  - Multiple redirects while drop=1: the latest target wins; only one response is discarded.
//  - PC arithmetic is modulo 2^XLEN: pc=32'hFFFF_FFFC + 4 wraps to 0.
//  - Bus error: inst_fault=1, inst=0; the PC advances normally on consume (trap unit redirects).
//  - rsp_valid outside WAIT is ignored.
//  - rst mid-transaction forces the reset state; the bus is reset by the same rst.
// STRUCTURE
//  - ifu_pkg: fetch_state_e {REQ,WAIT,HOLD,FLT}; fault_e {FLT_NONE,FLT_BUS,FLT_MISALIGN};
//    INST_W=32; NOP constant.
//  - Single module; the output buffer (inst/inst_pc/inst_fault/valid) is inline, no sub-module.
// TESTING
//  1 Reset PC_RST_VEC=0x100, zero-wait bus, ready=1 -> addrs 0x100,0x104,0x108; inst_valid every 3rd cycle.
//  2 Redirect pc_branch target 0x200 in WAIT -> old rsp dropped, inst_valid=0, next addr 0x200, inst_pc=0x200.
//  3 trap(0x80) and pc_branch(0x400) in the same cycle during HOLD with inst_ready=1 -> next addr 0x80.
//  4 target_pc=0x202 -> no ibus_req_valid; inst_valid with inst_fault=2, inst=0, inst_pc=0x202.
//  5 ibus_req_ready low 5 cycles plus a redirect at cycle 2 -> addr held stable; rsp discarded; then addr=target.
//  6 rsp_err=1 at pc 0x10 -> inst_fault=1, inst=0; after consume, next addr 0x14; rst mid-WAIT -> addr PC_RST_VEC.

Source files
------------

// File: rtl/ifu_fetch_ctrl_pkg.sv
// ============================================================================
// Module      : ifu_pkg
// Description : Shared types and constants for the instruction fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

    // FSM states kept as plain sized constants so legacy tools can consume them
    typedef logic [1:0] fetch_state_e;
    localparam fetch_state_e REQ  = 2'd0;
    localparam fetch_state_e WAIT = 2'd1;
    localparam fetch_state_e HOLD = 2'd2;
    localparam fetch_state_e FLT  = 2'd3;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_BUS      = 2'd1,
        FLT_MISALIGN = 2'd2
    } fault_e;

endpackage

`default_nettype wire

// File: rtl/ifu_fetch_ctrl.sv
// ============================================================================
// Module      : ifu_fetch_ctrl
// Description : Single-outstanding instruction fetch sequencer with redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch_ctrl
    import ifu_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] PC_RST_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_branch,
    input  logic [XLEN-1:0]   target_pc,
    input  logic              trap,
    input  logic [XLEN-1:0]   trap_pc,
    output logic              ibus_req_valid,
    input  logic              ibus_req_ready,
    output logic [XLEN-1:0]   ibus_req_addr,
    input  logic              ibus_rsp_valid,
    input  logic [INST_W-1:0] ibus_rsp_data,
    input  logic              ibus_rsp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic [1:0]        inst_fault
);

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              drop_q, drop_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
    fault_e            fault_q, fault_d;

    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              enter_req;

    assign redirect    = trap | pc_branch;
    assign redirect_pc = trap ? trap_pc : target_pc;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;
        enter_req = 1'b0;

        case (state_q)
            REQ: begin
                // An unaccepted request is never withdrawn; its response gets dropped instead
                if (ibus_req_ready) state_d = WAIT;
                if (redirect) begin
                    pc_d   = redirect_pc;
                    drop_d = 1'b1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (ibus_rsp_valid) begin
                        drop_d    = 1'b0;
                        enter_req = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (ibus_rsp_valid) begin
                    if (drop_q) begin
                        drop_d    = 1'b0;
                        enter_req = 1'b1;
                    end else begin
                        inst_d    = ibus_rsp_err ? '0 : ibus_rsp_data;
                        fault_d   = ibus_rsp_err ? FLT_BUS : FLT_NONE;
                        inst_pc_d = pc_q;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d      = redirect_pc;
                    enter_req = 1'b1;
                end else if (inst_ready) begin
                    pc_d      = pc_q + XLEN'(4);
                    enter_req = 1'b1;
                end
            end
            FLT: begin
                if (redirect) begin
                    pc_d      = redirect_pc;
                    enter_req = 1'b1;
                end else begin
                    inst_d    = '0;
                    fault_d   = FLT_MISALIGN;
                    inst_pc_d = pc_q;
                    state_d   = HOLD;
                end
            end
            default: state_d = REQ;
        endcase

        // Misaligned PCs never reach the bus; they are reported through the buffer
        if (enter_req) begin
            if (pc_d[1:0] != 2'b00) begin
                state_d = FLT;
            end else begin
                state_d = REQ;
                addr_d  = pc_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REQ;
            pc_q      <= PC_RST_VEC;
            addr_q    <= PC_RST_VEC;
            drop_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fault_q   <= FLT_NONE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
        end
    end

    assign ibus_req_valid = (state_q == REQ);
    assign ibus_req_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign inst_valid     = (state_q == HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_fault     = fault_q;

endmodule

`default_nettype wire
